// File: rtl/dma_run_ctrl.sv
// dma_run_ctrl: run controller for the 8237A DMA environment.
// Holds the DUT in reset for RESET_CYCLES after START, counts run cycles
// against a global timeout, performs a drained end-of-test handshake and
// flags per-channel DREQ-without-DACK stalls.
// Optional: define DMA_RUN_CTRL_ACK_STATS_EN to add per-channel DACK-cycle
// counters on the ACK_COUNT port.
module dma_run_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int RESET_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DRAIN_CYCLES   = 16,
    parameter int STALL_LIMIT    = 1024
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic                    END_REQ,
    input  logic [NUM_CH-1:0]       DREQ,
    input  logic [NUM_CH-1:0]       DACK,
    output logic                    DUT_RESET,
    output logic                    RUNNING,
    output logic                    DONE,
    output logic                    TIMEOUT,
    output logic [NUM_CH-1:0]       STALL,
    output logic [CNT_W-1:0]        CYCLE_COUNT
`ifdef DMA_RUN_CTRL_ACK_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] ACK_COUNT
`endif
);

    // Parameter sanity checks, resolved at elaboration
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $fatal(1, "dma_run_ctrl: NUM_CH must be 1..8");
    end
    if (CNT_W < 2) begin : g_bad_cnt_w
        $fatal(1, "dma_run_ctrl: CNT_W too small");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $fatal(1, "dma_run_ctrl: RESET_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2 || (CNT_W < 31 && TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_timeout
        $fatal(1, "dma_run_ctrl: TIMEOUT_CYCLES must be >= 2 and < 2**CNT_W");
    end
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
        $fatal(1, "dma_run_ctrl: DRAIN_CYCLES must be >= 1");
    end
    if (STALL_LIMIT < 1 || (CNT_W < 31 && STALL_LIMIT >= (1 << CNT_W))) begin : g_bad_stall
        $fatal(1, "dma_run_ctrl: STALL_LIMIT must be >= 1 and fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT);
    localparam logic [31:0]      HOLD_LOAD  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]      DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_TMO
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       phase_reg, phase_next;   // shared hold / drain down-counter
    logic [CNT_W-1:0]  cycle_reg;
    logic              dut_reset_reg, running_reg, done_reg, timeout_reg;
    logic              active;       // current cycle is a run cycle
    logic              stay_active;  // run continues past this edge
    logic              restart;      // START accepted this cycle

    assign active      = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign stay_active = active && ((state_next == S_RUN) || (state_next == S_DRAIN));
    assign restart     = START && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                                   (state_reg == S_TMO));

    // State and phase-counter register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= S_IDLE;
            phase_reg <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    // Next-state logic; the timeout check outranks END_REQ and drain completion
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_TMO: begin
                if (START) begin
                    state_next = S_HOLD;
                    phase_next = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (phase_reg == '0) state_next = S_RUN;
                else                 phase_next = phase_reg - 32'd1;
            end
            S_RUN: begin
                if (cycle_reg == TMO_LAST) begin
                    state_next = S_TMO;
                end else if (END_REQ) begin
                    state_next = S_DRAIN;
                    phase_next = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (cycle_reg == TMO_LAST)  state_next = S_TMO;
                else if (phase_reg == '0)   state_next = S_DONE;
                else                        phase_next = phase_reg - 32'd1;
            end
            default: begin
                state_next = S_IDLE;
                phase_next = '0;
            end
        endcase
    end

    // Registered Moore outputs, decoded from the state being entered
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dut_reset_reg <= 1'b1;
            running_reg   <= 1'b0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            dut_reset_reg <= !((state_next == S_RUN) || (state_next == S_DRAIN) ||
                               (state_next == S_DONE));
            running_reg   <= (state_next == S_RUN) || (state_next == S_DRAIN);
            done_reg      <= (state_next == S_DONE);
            timeout_reg   <= (state_next == S_TMO);
        end
    end

    // Run-cycle counter: counts only while the run continues, so it freezes on exit
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)           cycle_reg <= '0;
        else if (restart)     cycle_reg <= '0;
        else if (stay_active) cycle_reg <= cycle_reg + 1'b1;
    end

    assign DUT_RESET   = dut_reset_reg;
    assign RUNNING     = running_reg;
    assign DONE        = done_reg;
    assign TIMEOUT     = timeout_reg;
    assign CYCLE_COUNT = cycle_reg;

    // Per-channel stall watch (and optional DACK statistics)
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
        logic             stall_reg;

        // Consecutive DREQ-without-DACK cycles, saturating; zero outside a run
        always_comb begin
            stall_cnt_next = '0;
            if (active && DREQ[gi] && !DACK[gi])
                stall_cnt_next = (stall_cnt_reg == STALL_MAX) ? STALL_MAX
                                                              : stall_cnt_reg + 1'b1;
        end

        // Stall counter and sticky flag
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                stall_cnt_reg <= '0;
                stall_reg     <= 1'b0;
            end else if (restart) begin
                stall_cnt_reg <= '0;
                stall_reg     <= 1'b0;
            end else begin
                stall_cnt_reg <= stall_cnt_next;
                if (stall_cnt_next == STALL_MAX) stall_reg <= 1'b1;
            end
        end

        assign STALL[gi] = stall_reg;

`ifdef DMA_RUN_CTRL_ACK_STATS_EN
        logic [CNT_W-1:0] ack_cnt_reg;

        // Saturating count of DACK-high run cycles
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET)
                ack_cnt_reg <= '0;
            else if (restart)
                ack_cnt_reg <= '0;
            else if (active && DACK[gi] && (ack_cnt_reg != '1))
                ack_cnt_reg <= ack_cnt_reg + 1'b1;
        end

        assign ACK_COUNT[gi*CNT_W +: CNT_W] = ack_cnt_reg;
`endif
    end

endmodule
